fifo_ctrl_3port: RTL and testbench
==================================

# fifo_ctrl_3port

Synchronous FIFO controller that drives the team's 3-port RAM (one synchronous write port, one asynchronous read port, one synchronous read port) and wraps it in valid/ready push and pop streams. The block owns the read and write pointers, occupancy count and flags, and sits between a producer stream and a consumer stream, with the RAM instantiated beside it. An optional peek path uses the RAM's second read port for random-access inspection of queued entries.

## Interface
- ADDR_WIDTH, 3, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH
- DATA_WIDTH, 8, entry width in bits
- clk  input  1  rising-edge clock for all state
- rst_n  input  1  asynchronous, active-low reset; deassertion synchronous to clk by the system
- flush  input  1  synchronous clear of all FIFO contents
- push_valid  input  1  producer has data
- push_ready  output  1  FIFO accepts data (= !full)
- push_data  input  DATA_WIDTH  producer data
- pop_valid  output  1  head entry available (= !empty)
- pop_ready  input  1  consumer takes head
- pop_data  output  DATA_WIDTH  head entry, first-word-fall-through
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- full, empty  output  1 each  occupancy flags
- ram_w_addr, ram_w_data, ram_we  output  ADDR_WIDTH / DATA_WIDTH / 1  RAM write port
- ram_r_addr0  output  ADDR_WIDTH  RAM async read address (head)
- ram_r_data0  input  DATA_WIDTH  RAM async read data
- ram_r_addr1  output  ADDR_WIDTH  RAM sync read address (peek)
- ram_r_data1  input  DATA_WIDTH  RAM sync read data, valid one cycle after address
- peek_req  input  1  peek request (PEEK_EN only)
- peek_idx  input  ADDR_WIDTH  offset from head, 0 = head (PEEK_EN only)
- peek_valid  output  1  peek result valid (PEEK_EN only)
- peek_data  output  DATA_WIDTH  peek result (PEEK_EN only)

## Operation
- Pointers wr_ptr, rd_ptr are ADDR_WIDTH+1 bits; low ADDR_WIDTH bits address the RAM, MSB is the wrap bit.
- empty = (wr_ptr == rd_ptr); full = low bits equal and MSBs differ; count = wr_ptr - rd_ptr modulo 2**(ADDR_WIDTH+1).
- Push fires when push_valid && push_ready: ram_we=1, ram_w_addr=wr_ptr[ADDR_WIDTH-1:0], ram_w_data=push_data (combinational), wr_ptr increments at clock edge.
- Pop fires when pop_valid && pop_ready: rd_ptr increments at clock edge. ram_r_addr0 = rd_ptr low bits always; pop_data = ram_r_data0 combinationally.
- Simultaneous push and pop: both fire if individually allowed; count unchanged.
- Full: push_ready low even if pop fires the same cycle (no pass-through on full).
- Empty: pop_valid low; a push into empty FIFO makes pop_valid high the next cycle with pop_data = pushed word.
- Wrap: pointer low bits roll DEPTH-1 -> 0; MSB toggles.
- flush: wr_ptr, rd_ptr <= 0 at next edge; ram_we forced 0 in the flush cycle; push/pop ignored. RAM contents not cleared.
- ram_we is never asserted when push_ready is low; no other output gated by pop_ready.

## Timing
- Reset (rst_n low, asynchronous): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, push_ready=1, pop_valid=0, ram_we=0, peek_valid=0, peek_data=0. Reset mid-operation discards contents immediately.
- Push-to-pop latency: 1 cycle (write at edge N, pop_valid at N+1 when FIFO was empty).
- Flags and count are registered-pointer derived; they update the cycle after the firing edge.
- Peek latency: 1 cycle; peek_valid registered, high the cycle after peek_req.

## Configuration
- PEEK_EN defined: ram_r_addr1 = (rd_ptr + peek_idx) low bits; peek_valid <= peek_req && (peek_idx < count); peek_data = ram_r_data1 when peek_valid, else 0. Out-of-range peek returns peek_valid=0.
- PEEK_EN undefined: peek ports absent; ram_r_addr1 tied to 0.

## Structure
- Package fifo_ctrl_pkg: ptr_t / cnt_t width helpers (ADDR_WIDTH+1), localparam DEPTH function, reset-value constants.
- Sub-module fifo_ptr_ctr: one instance per pointer; inc, clr, async rst_n, ADDR_WIDTH+1-bit wrapping counter.

## Test plan
- Reset then idle -> empty=1, full=0, count=0, push_ready=1, pop_valid=0, ram_we=0.
- Push 0x11..0x18 (8 words, ADDR_WIDTH=3) -> full=1, count=8, push_ready=0; 9th push 0x99 not written (ram_we=0).
- Pop 8 from full -> pop_data 0x11..0x18 in order, empty=1 after last; pointers wrapped (MSB=1, low bits 0).
- Steady push+pop every cycle at count=4 for 20 cycles -> count stays 4, data order preserved across wrap.
- flush at count=5 with push_valid high -> next cycle count=0, empty=1, no RAM write in flush cycle.
- PEEK_EN: push 0xA0..0xA3, peek_idx=2 -> next cycle peek_valid=1, peek_data=0xA2; peek_idx=5 -> peek_valid=0.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared widths, default sizing and reset constants for the 3-port FIFO controller.
package fifo_ctrl_pkg;

  localparam int unsigned FIFO_AW_DEF = 3;
  localparam int unsigned FIFO_DW_DEF = 8;

  typedef logic [FIFO_AW_DEF:0] ptr_t;
  typedef logic [FIFO_AW_DEF:0] cnt_t;

  localparam logic RST_EMPTY      = 1'b1;
  localparam logic RST_FULL       = 1'b0;
  localparam logic RST_PEEK_VALID = 1'b0;

  function automatic int unsigned ptr_width(input int unsigned aw);
    return aw + 1;
  endfunction

  function automatic int unsigned fifo_depth(input int unsigned aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/fifo_ctrl_3port_if.sv
// Push/pop valid-ready stream bundle between producer/consumer (master) and FIFO (slave).
interface fifo_ctrl_3port_if
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_DW_DEF
);
  logic                  push_valid;
  logic                  push_ready;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  pop_valid;
  logic                  pop_ready;
  logic [DATA_WIDTH-1:0] pop_data;

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data
  );
endinterface

// File: rtl/fifo_ptr_ctr.sv
// Wrapping FIFO pointer: low bits address the RAM, MSB is the lap bit; clr beats inc.
module fifo_ptr_ctr
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned W = ptr_width(FIFO_AW_DEF)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (clr) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl_3port.sv
// FIFO controller around a 3-port RAM (sync write, async head read, sync peek read).
// Optional random-access peek path is built when PEEK_EN is defined.
module fifo_ctrl_3port
  import fifo_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = FIFO_AW_DEF,
  parameter int unsigned DATA_WIDTH = FIFO_DW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  fifo_ctrl_3port_if.slave      s,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_r_addr0,
  input  logic [DATA_WIDTH-1:0] ram_r_data0,
  output logic [ADDR_WIDTH-1:0] ram_r_addr1,
  input  logic [DATA_WIDTH-1:0] ram_r_data1
`ifdef PEEK_EN
  ,
  input  logic                  peek_req,
  input  logic [ADDR_WIDTH-1:0] peek_idx,
  output logic                  peek_valid,
  output logic [DATA_WIDTH-1:0] peek_data
`endif
);

  localparam int unsigned PW = ptr_width(ADDR_WIDTH);

  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_rd_ptr;
  logic          w_full;
  logic          w_empty;
  logic          w_push_fire;
  logic          w_pop_fire;

  assign w_empty = (w_wr_ptr == w_rd_ptr);
  assign w_full  = (w_wr_ptr[ADDR_WIDTH-1:0] == w_rd_ptr[ADDR_WIDTH-1:0]) &&
                   (w_wr_ptr[ADDR_WIDTH] != w_rd_ptr[ADDR_WIDTH]);

  // push_ready ignores pop_ready: a full FIFO never passes a word through.
  assign s.push_ready = !w_full;
  assign s.pop_valid  = !w_empty;
  assign s.pop_data   = ram_r_data0;

  assign w_push_fire = s.push_valid && !w_full  && !flush;
  assign w_pop_fire  = s.pop_ready  && !w_empty && !flush;

  assign full  = w_full;
  assign empty = w_empty;
  assign count = w_wr_ptr - w_rd_ptr;

  assign ram_we      = w_push_fire;
  assign ram_w_addr  = w_wr_ptr[ADDR_WIDTH-1:0];
  assign ram_w_data  = s.push_data;
  assign ram_r_addr0 = w_rd_ptr[ADDR_WIDTH-1:0];

  fifo_ptr_ctr #(.W(PW)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_push_fire),
    .clr   (flush),
    .ptr   (w_wr_ptr)
  );

  fifo_ptr_ctr #(.W(PW)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_pop_fire),
    .clr   (flush),
    .ptr   (w_rd_ptr)
  );

`ifdef PEEK_EN
  logic                  r_peek_valid;
  logic [ADDR_WIDTH-1:0] w_peek_addr;
  logic                  w_peek_in_range;

  assign w_peek_addr     = w_rd_ptr[ADDR_WIDTH-1:0] + peek_idx;
  assign w_peek_in_range = ({1'b0, peek_idx} < count);
  assign ram_r_addr1     = w_peek_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_peek_valid <= RST_PEEK_VALID;
    end else begin
      r_peek_valid <= peek_req && w_peek_in_range;
    end
  end

  assign peek_valid = r_peek_valid;
  assign peek_data  = r_peek_valid ? ram_r_data1 : '0;
`else
  logic w_unused_rdata1;

  assign ram_r_addr1     = '0;
  assign w_unused_rdata1 = ^ram_r_data1;
`endif

endmodule

// File: tb/tb_fifo_ctrl_3port.sv
// Directed vector bench for fifo_ctrl_3port with a behavioural 3-port RAM beside it.
module tb_fifo_ctrl_3port;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic [3:0] count;
  logic       full, empty;
  logic [2:0] ram_w_addr, ram_r_addr0, ram_r_addr1;
  logic [7:0] ram_w_data, ram_r_data0, ram_r_data1;
  logic       ram_we;
`ifdef PEEK_EN
  logic       peek_req;
  logic [2:0] peek_idx;
  logic       peek_valid;
  logic [7:0] peek_data;
`endif

  int total = 0;
  int bad   = 0;
  int n_writes = 0;

  always #5 clk = ~clk;

  fifo_ctrl_3port_if #(.DATA_WIDTH(8)) sif ();

  fifo_ctrl_3port #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .s           (sif.slave),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .ram_w_addr  (ram_w_addr),
    .ram_w_data  (ram_w_data),
    .ram_we      (ram_we),
    .ram_r_addr0 (ram_r_addr0),
    .ram_r_data0 (ram_r_data0),
    .ram_r_addr1 (ram_r_addr1),
    .ram_r_data1 (ram_r_data1)
`ifdef PEEK_EN
    ,
    .peek_req    (peek_req),
    .peek_idx    (peek_idx),
    .peek_valid  (peek_valid),
    .peek_data   (peek_data)
`endif
  );

  logic [7:0] mem [8];
  initial for (int k = 0; k < 8; k++) mem[k] = 8'h00;
  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_w_addr] <= ram_w_data;
      n_writes <= n_writes + 1;
    end
  end
  assign ram_r_data0 = mem[ram_r_addr0];
  always @(posedge clk) ram_r_data1 <= mem[ram_r_addr1];

  typedef struct {
    logic       pv;
    logic [7:0] pd;
    logic       pr;
    logic       fl;
    int         cnt;
    logic       full;
    logic       empty;
    logic       popv;
    logic [7:0] popd;
    logic       we;
    int         waddr;
    int         raddr0;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic [7:0] pd, input logic pr, input logic fl);
    sif.push_valid = pv;
    sif.push_data  = pd;
    sif.pop_ready  = pr;
    flush          = fl;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int wr_before;

    // Push 0x11..0x18, one refused push at full, then drain 8 back out.
    for (int i = 0; i < 8; i++)
      vt[i] = '{1'b1, 8'(8'h11 + i), 1'b0, 1'b0, i, 1'b0, (i == 0), (i != 0), 8'h11, 1'b1, i, 0};
    vt[8] = '{1'b1, 8'h99, 1'b0, 1'b0, 8, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0, 0, 0};
    for (int j = 0; j < 8; j++)
      vt[9 + j] = '{1'b0, 8'h00, 1'b1, 1'b0, 8 - j, (j == 0), 1'b0, 1'b1, 8'(8'h11 + j), 1'b0, 0, j};
    vt[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 0, 0};

    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
`ifdef PEEK_EN
    peek_req = 1'b0;
    peek_idx = 3'd0;
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst.count", 32'(count), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.push_ready", 32'(sif.push_ready), 1);
    chk("rst.pop_valid", 32'(sif.pop_valid), 0);
    chk("rst.ram_we", 32'(ram_we), 0);
`ifdef PEEK_EN
    chk("rst.peek_valid", 32'(peek_valid), 0);
    chk("rst.peek_data", 32'(peek_data), 0);
`else
    chk("rst.ram_r_addr1", 32'(ram_r_addr1), 0);
`endif
    adv();

    for (int i = 0; i < 18; i++) begin
      drive(vt[i].pv, vt[i].pd, vt[i].pr, vt[i].fl);
      @(negedge clk);
      chk($sformatf("v%0d.count", i), 32'(count), 32'(vt[i].cnt));
      chk($sformatf("v%0d.full", i), 32'(full), 32'(vt[i].full));
      chk($sformatf("v%0d.empty", i), 32'(empty), 32'(vt[i].empty));
      chk($sformatf("v%0d.push_ready", i), 32'(sif.push_ready), 32'(!vt[i].full));
      chk($sformatf("v%0d.pop_valid", i), 32'(sif.pop_valid), 32'(vt[i].popv));
      if (vt[i].popv)
        chk($sformatf("v%0d.pop_data", i), 32'(sif.pop_data), 32'(vt[i].popd));
      chk($sformatf("v%0d.ram_we", i), 32'(ram_we), 32'(vt[i].we));
      if (vt[i].we)
        chk($sformatf("v%0d.ram_w_data", i), 32'(ram_w_data), 32'(vt[i].pd));
      chk($sformatf("v%0d.ram_w_addr", i), 32'(ram_w_addr), 32'(vt[i].waddr));
      chk($sformatf("v%0d.ram_r_addr0", i), 32'(ram_r_addr0), 32'(vt[i].raddr0));
      adv();
    end

    // Steady-state: fill to 4, then push+pop every cycle across the RAM wrap.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(8'h20 + k), 1'b0, 1'b0);
      adv();
    end
    for (int k = 0; k < 20; k++) begin
      drive(1'b1, 8'(8'h24 + k), 1'b1, 1'b0);
      @(negedge clk);
      chk($sformatf("ss%0d.count", k), 32'(count), 4);
      chk($sformatf("ss%0d.pop_data", k), 32'(sif.pop_data), 32'(8'h20 + k));
      chk($sformatf("ss%0d.ram_we", k), 32'(ram_we), 1);
      adv();
    end

    // Flush at count=5 with push_valid still high.
    drive(1'b1, 8'h38, 1'b0, 1'b0);
    adv();
    drive(1'b1, 8'hEE, 1'b1, 1'b1);
    @(negedge clk);
    chk("flush.count_before", 32'(count), 5);
    chk("flush.ram_we", 32'(ram_we), 0);
    wr_before = n_writes;
    adv();
    chk("flush.no_write", 32'(n_writes), 32'(wr_before));
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("flush.count_after", 32'(count), 0);
    chk("flush.empty", 32'(empty), 1);
    chk("flush.pop_valid", 32'(sif.pop_valid), 0);
    adv();

    // Asynchronous reset in the middle of operation.
    drive(1'b1, 8'h50, 1'b0, 1'b0);
    adv();
    drive(1'b1, 8'h51, 1'b0, 1'b0);
    adv();
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    chk("mid.count_before", 32'(count), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.count", 32'(count), 0);
    chk("mid.empty", 32'(empty), 1);
    chk("mid.pop_valid", 32'(sif.pop_valid), 0);
    chk("mid.push_ready", 32'(sif.push_ready), 1);
    @(posedge clk);
    #1 rst_n = 1'b1;

`ifdef PEEK_EN
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 8'(8'hA0 + k), 1'b0, 1'b0);
      adv();
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    peek_req = 1'b1;
    peek_idx = 3'd2;
    adv();
    peek_idx = 3'd3;
    @(negedge clk);
    chk("peek2.valid", 32'(peek_valid), 1);
    chk("peek2.data", 32'(peek_data), 32'h A2);
    adv();
    peek_idx = 3'd5;
    @(negedge clk);
    chk("peek3.valid", 32'(peek_valid), 1);
    chk("peek3.data", 32'(peek_data), 32'hA3);
    adv();
    peek_req = 1'b0;
    @(negedge clk);
    chk("peek5.valid", 32'(peek_valid), 0);
    chk("peek5.data", 32'(peek_data), 0);
    adv();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
